// File: rtl/writeback_queue.sv
// writeback_queue: merges single-cycle ALU results and backpressured
// long-latency results onto one registered register-file write port.
// Long results wait in a DEPTH-entry FIFO and drain only in cycles where
// the ALU is not writing. Writes to register 0 are dropped on both paths.
//
// Long handshake: a transfer happens in a cycle where LongValid and
// LongReady are both high at the rising edge of Clock. LongReady comes only
// from registered state (Reset and Count), never from LongValid or from a
// same-cycle pop. LongAddr/LongData only need to be stable while LongValid
// is high, and the producer keeps offering until it sees LongReady.
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     AluWrite,
  input  logic [4:0]               AluAddr,
  input  logic [WIDTH-1:0]         AluData,
  input  logic                     LongValid,
  output logic                     LongReady,
  input  logic [4:0]               LongAddr,
  input  logic [WIDTH-1:0]         LongData,
  input  logic [4:0]               RsAddr,
  input  logic [4:0]               RtAddr,
  output logic                     RsPending,
  output logic                     RtPending,
  output logic                     RegWrite,
  output logic [4:0]               RdAddr,
  output logic [WIDTH-1:0]         RdData,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // FIFO storage; never cleared, validity comes from head and count
  logic [4:0]       mem_addr [DEPTH];
  logic [WIDTH-1:0] mem_data [DEPTH];

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             reg_write;
  logic [4:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;

  logic             long_ready;
  logic             long_fire;
  logic             push;
  logic             alu_sel;
  logic             pop;
  logic             rs_hit;
  logic             rt_hit;

  // Ready looks only at registered occupancy so a full queue stays closed
  // for the whole cycle even when it is draining.
  assign long_ready = ~Reset & (count < CW'(DEPTH));
  assign long_fire  = LongValid & long_ready;
  // A handshake to register 0 completes but stores nothing.
  assign push       = long_fire & (LongAddr != 5'd0);
  // An ALU write to register 0 is no write at all, freeing the port.
  assign alu_sel    = AluWrite & (AluAddr != 5'd0);
  // The pop sees only the registered count, so a just-pushed entry waits.
  assign pop        = ~alu_sel & (count != '0);

  assign LongReady = long_ready;
  assign RegWrite  = reg_write;
  assign RdAddr    = rd_addr;
  assign RdData    = rd_data;
  assign Count     = count;

  // Capture accepted long results at the tail slot
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_addr[tail] <= LongAddr;
      mem_data[tail] <= LongData;
    end
  end

  // Pointers, occupancy and the registered write port
  always_ff @(posedge Clock) begin
    if (Reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      reg_write <= 1'b0;
      rd_addr   <= 5'd0;
      rd_data   <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (alu_sel) begin
        reg_write <= 1'b1;
        rd_addr   <= AluAddr;
        rd_data   <= AluData;
      end else if (pop) begin
        reg_write <= 1'b1;
        rd_addr   <= mem_addr[head];
        rd_data   <= mem_data[head];
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

  // Search the occupied FIFO slots for either operand register
  always_comb begin
    logic [PW-1:0] slot;
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // distance of slot i from the head, modulo DEPTH
      slot = PW'(i) - head;
      if ({1'b0, slot} < count) begin
        if (mem_addr[i] == RsAddr) begin
          rs_hit = 1'b1;
        end
        if (mem_addr[i] == RtAddr) begin
          rt_hit = 1'b1;
        end
      end
    end
  end

  // An operand is pending while queued or sitting in the uncommitted output
  always_comb begin
    RsPending = (RsAddr != 5'd0) & (rs_hit | (reg_write & (rd_addr == RsAddr)));
    RtPending = (RtAddr != 5'd0) & (rt_hit | (reg_write & (rd_addr == RtAddr)));
  end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed vector table for the documented scenarios,
// then randomized traffic checked against a queue-based reference model.
module tb_writeback_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = 5 + WIDTH;

  // ---------------------------------------------------------------- clock/reset
  logic             Clock = 1'b0;
  logic             Reset;
  logic             AluWrite;
  logic [4:0]       AluAddr;
  logic [WIDTH-1:0] AluData;
  logic             LongValid;
  logic             LongReady;
  logic [4:0]       LongAddr;
  logic [WIDTH-1:0] LongData;
  logic [4:0]       RsAddr;
  logic [4:0]       RtAddr;
  logic             RsPending;
  logic             RtPending;
  logic             RegWrite;
  logic [4:0]       RdAddr;
  logic [WIDTH-1:0] RdData;
  logic [CW-1:0]    Count;

  always #5 Clock = ~Clock;

  writeback_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .AluWrite  (AluWrite),
    .AluAddr   (AluAddr),
    .AluData   (AluData),
    .LongValid (LongValid),
    .LongReady (LongReady),
    .LongAddr  (LongAddr),
    .LongData  (LongData),
    .RsAddr    (RsAddr),
    .RtAddr    (RtAddr),
    .RsPending (RsPending),
    .RtPending (RtPending),
    .RegWrite  (RegWrite),
    .RdAddr    (RdAddr),
    .RdData    (RdData),
    .Count     (Count)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  // reference model: queued {addr,data} writes plus the expected write port
  logic [EW-1:0]    exp_q[$];
  logic             m_rw;
  logic [4:0]       m_ra;
  logic [WIDTH-1:0] m_rd;
  logic             model_live = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_pending(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (m_rw && m_ra == a) return 1'b1;
    foreach (exp_q[i]) if (exp_q[i][EW-1:WIDTH] == a) return 1'b1;
    return 1'b0;
  endfunction

  // compare every DUT output with the model, mid-cycle with inputs applied
  task automatic check_model();
    check("m_ready", LongReady, !Reset && (exp_q.size() < DEPTH));
    check("m_count", Count, exp_q.size());
    check("m_regwrite", RegWrite, m_rw);
    check("m_rdaddr", RdAddr, m_ra);
    check("m_rddata", RdData, m_rd);
    check("m_rspend", RsPending, m_pending(RsAddr));
    check("m_rtpend", RtPending, m_pending(RtAddr));
  endtask

  // advance the model across one rising edge using the applied inputs
  task automatic model_edge();
    logic ready;
    logic [EW-1:0] e;
    ready = !Reset && (exp_q.size() < DEPTH);
    if (Reset) begin
      exp_q.delete();
      m_rw = 1'b0;
      m_ra = 5'd0;
      m_rd = '0;
    end else begin
      if (AluWrite && AluAddr != 5'd0) begin
        m_rw = 1'b1;
        m_ra = AluAddr;
        m_rd = AluData;
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_rw = 1'b1;
        m_ra = e[EW-1:WIDTH];
        m_rd = e[WIDTH-1:0];
      end else begin
        m_rw = 1'b0;
      end
      if (LongValid && ready && LongAddr != 5'd0) exp_q.push_back({LongAddr, LongData});
    end
  endtask

  // write port must never target register 0
  always @(negedge Clock) begin
    if (model_live) begin
      checks++;
      if (RegWrite === 1'b1 && RdAddr === 5'd0) begin
        errors++;
        $display("FAIL reg0_write: got RegWrite=1 RdAddr=0 expected no write to r0 (t=%0t)", $time);
      end
    end
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic             rst, aw;
    logic [4:0]       aa;
    logic [WIDTH-1:0] ad;
    logic             lv;
    logic [4:0]       la;
    logic [WIDTH-1:0] ld;
    logic [4:0]       rs, rt;
    logic             pre;
    logic             e_ready, e_rsp, e_rtp;
    logic             e_rw;
    logic [4:0]       e_ra;
    logic [WIDTH-1:0] e_rd;
    logic [CW-1:0]    e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, aw, input logic [4:0] aa, input logic [WIDTH-1:0] ad,
                     input logic lv, input logic [4:0] la, input logic [WIDTH-1:0] ld,
                     input logic [4:0] rs, rt, input logic pre, rdy, rsp, rtp,
                     input logic rw, input logic [4:0] ra, input logic [WIDTH-1:0] rd,
                     input logic [CW-1:0] cnt);
    vec_t v;
    v.rst = rst; v.aw = aw; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.rs = rs; v.rt = rt; v.pre = pre; v.e_ready = rdy; v.e_rsp = rsp; v.e_rtp = rtp;
    v.e_rw = rw; v.e_ra = ra; v.e_rd = rd; v.e_cnt = cnt;
    tbl.push_back(v);
  endtask

  // ---------------------------------------------------------------- driver
  // apply one cycle of inputs, check mid-cycle, cross the edge, check after
  task automatic step(input vec_t v, input logic use_tbl, input int idx);
    Reset = v.rst; AluWrite = v.aw; AluAddr = v.aa; AluData = v.ad;
    LongValid = v.lv; LongAddr = v.la; LongData = v.ld; RsAddr = v.rs; RtAddr = v.rt;
    #3;
    if (model_live) check_model();
    if (use_tbl && v.pre) begin
      check($sformatf("v%0d_ready", idx), LongReady, v.e_ready);
      check($sformatf("v%0d_rspend", idx), RsPending, v.e_rsp);
      check($sformatf("v%0d_rtpend", idx), RtPending, v.e_rtp);
    end
    @(posedge Clock);
    model_edge();
    model_live = 1'b1;
    #1;
    if (use_tbl) begin
      check($sformatf("v%0d_regwrite", idx), RegWrite, v.e_rw);
      check($sformatf("v%0d_rdaddr", idx), RdAddr, v.e_ra);
      check($sformatf("v%0d_rddata", idx), RdData, v.e_rd);
      check($sformatf("v%0d_count", idx), Count, v.e_cnt);
    end
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    vec_t r;
    Reset = 1'b1; AluWrite = 1'b0; AluAddr = '0; AluData = '0;
    LongValid = 1'b0; LongAddr = '0; LongData = '0; RsAddr = '0; RtAddr = '0;
    m_rw = 1'b0; m_ra = '0; m_rd = '0;
    @(posedge Clock); #1;

    //   rst aw aa  ad            lv la  ld           rs  rt  pre rdy rsp rtp  rw ra  rd            cnt
    add(1, 0, 0,  0,            0, 0,  0,           0,  0,  0,  0,  0,  0,   0, 0,  0,            0);
    // ALU write, 1-cycle latency, then idle holds data
    add(0, 1, 5,  32'hA5A5A5A5, 0, 0,  0,           0,  0,  1,  1,  0,  0,   1, 5,  32'hA5A5A5A5, 0);
    add(0, 0, 0,  0,            0, 0,  0,           5,  0,  1,  1,  1,  0,   0, 5,  32'hA5A5A5A5, 0);
    // two long pushes drain in order, count 0,1,1,0
    add(0, 0, 0,  0,            1, 3,  32'h11,      0,  0,  1,  1,  0,  0,   0, 5,  32'hA5A5A5A5, 1);
    add(0, 0, 0,  0,            1, 4,  32'h22,      3,  4,  1,  1,  1,  0,   1, 3,  32'h11,       1);
    add(0, 0, 0,  0,            0, 0,  0,           3,  4,  1,  1,  1,  1,   1, 4,  32'h22,       0);
    add(0, 0, 0,  0,            0, 0,  0,           3,  4,  1,  1,  0,  1,   0, 4,  32'h22,       0);
    // ALU busy while filling the queue
    add(0, 1, 7,  32'h70,       1, 1,  32'h101,     0,  0,  1,  1,  0,  0,   1, 7,  32'h70,       1);
    add(0, 1, 7,  32'h71,       1, 2,  32'h102,     0,  0,  1,  1,  0,  0,   1, 7,  32'h71,       2);
    add(0, 1, 7,  32'h72,       1, 3,  32'h103,     0,  0,  1,  1,  0,  0,   1, 7,  32'h72,       3);
    add(0, 1, 7,  32'h73,       1, 4,  32'h104,     0,  0,  1,  1,  0,  0,   1, 7,  32'h73,       4);
    add(0, 1, 7,  32'h74,       1, 5,  32'h105,     1,  6,  1,  0,  1,  0,   1, 7,  32'h74,       4);
    // ALU drops: pop while full, offer still refused this cycle
    add(0, 0, 0,  0,            1, 5,  32'h105,     7,  0,  1,  0,  1,  0,   1, 1,  32'h101,      3);
    add(0, 0, 0,  0,            1, 5,  32'h105,     0,  0,  1,  1,  0,  0,   1, 2,  32'h102,      3);
    add(0, 0, 0,  0,            0, 0,  0,           0,  0,  1,  1,  0,  0,   1, 3,  32'h103,      2);
    add(0, 0, 0,  0,            0, 0,  0,           0,  0,  1,  1,  0,  0,   1, 4,  32'h104,      1);
    add(0, 0, 0,  0,            0, 0,  0,           0,  0,  1,  1,  0,  0,   1, 5,  32'h105,      0);
    add(0, 0, 0,  0,            0, 0,  0,           0,  0,  1,  1,  0,  0,   0, 5,  32'h105,      0);
    // register 0 on both paths
    add(0, 1, 0,  32'hBEEF,     1, 0,  32'hDEAD,    0,  0,  1,  1,  0,  0,   0, 5,  32'h105,      0);
    add(0, 0, 0,  0,            1, 6,  32'h66,      0,  0,  1,  1,  0,  0,   0, 5,  32'h105,      1);
    add(0, 1, 0,  32'hBEEF,     0, 0,  0,           0,  0,  1,  1,  0,  0,   1, 6,  32'h66,       0);
    add(0, 0, 0,  0,            0, 0,  0,           0,  0,  1,  1,  0,  0,   0, 6,  32'h66,       0);
    // pending lookup through queue and output register
    add(0, 1, 8,  32'h88,       1, 9,  32'h99,      9,  0,  1,  1,  0,  0,   1, 8,  32'h88,       1);
    add(0, 1, 8,  32'h89,       0, 0,  0,           9,  0,  1,  1,  1,  0,   1, 8,  32'h89,       1);
    add(0, 0, 0,  0,            0, 0,  0,           9,  0,  1,  1,  1,  0,   1, 9,  32'h99,       0);
    add(0, 0, 0,  0,            0, 0,  0,           9,  0,  1,  1,  1,  0,   0, 9,  32'h99,       0);
    add(0, 0, 0,  0,            0, 0,  0,           9,  0,  1,  1,  0,  0,   0, 9,  32'h99,       0);
    // reset mid-operation discards queued writes
    add(0, 1, 10, 32'hA0,       1, 11, 32'hB1,      0,  0,  1,  1,  0,  0,   1, 10, 32'hA0,       1);
    add(0, 1, 10, 32'hA1,       1, 12, 32'hB2,      0,  0,  1,  1,  0,  0,   1, 10, 32'hA1,       2);
    add(0, 1, 10, 32'hA2,       1, 13, 32'hB3,      0,  0,  1,  1,  0,  0,   1, 10, 32'hA2,       3);
    add(1, 0, 0,  0,            1, 14, 32'hB4,      11, 0,  1,  0,  1,  0,   0, 0,  0,            0);
    add(0, 0, 0,  0,            0, 0,  0,           11, 0,  1,  1,  0,  0,   0, 0,  0,            0);
    add(0, 0, 0,  0,            0, 0,  0,           11, 0,  1,  1,  0,  0,   0, 0,  0,            0);

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, i);

    // randomized traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      r.rst = ($urandom_range(0, 99) == 0);
      r.aw  = ($urandom_range(0, 99) < 45);
      r.aa  = 5'($urandom_range(0, 7));
      r.ad  = $urandom;
      r.lv  = ($urandom_range(0, 99) < 60);
      r.la  = 5'($urandom_range(0, 7));
      r.ld  = $urandom;
      r.rs  = 5'($urandom_range(0, 7));
      r.rt  = 5'($urandom_range(0, 7));
      r.pre = 1'b0; r.e_ready = 1'b0; r.e_rsp = 1'b0; r.e_rtp = 1'b0;
      r.e_rw = 1'b0; r.e_ra = '0; r.e_rd = '0; r.e_cnt = '0;
      step(r, 1'b0, n);
    end

    // final state against the model
    Reset = 1'b0; AluWrite = 1'b0; LongValid = 1'b0;
    #3;
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
